// File: rtl/sync_pkg.sv
// Shared definitions for the data_sync destination-domain synchronizer.
package sync_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FULL = 1'b1
    } sync_state_e;

    localparam int DEFAULT_NUM_STAGES = 2;
    localparam int DEFAULT_BUS_WIDTH  = 8;
    localparam int DEFAULT_CNT_WIDTH  = 4;

endpackage

// File: rtl/bit_sync.sv
// Resettable multi-flop synchronizer chain; q is the last stage.
module bit_sync #(
    parameter int WIDTH      = 1,
    parameter int NUM_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [NUM_STAGES-1:0][WIDTH-1:0] chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[NUM_STAGES-2:0], d};
        end
    end

    assign q = chain[NUM_STAGES-1];

endmodule

// File: rtl/data_sync.sv
// Synchronizes bus_enable, captures unsync_bus on its rise into a one-word
// valid/ready slot, and flags/counts words dropped while the slot is full.
module data_sync
    import sync_pkg::*;
#(
    parameter int NUM_STAGES = DEFAULT_NUM_STAGES,
    parameter int BUS_WIDTH  = DEFAULT_BUS_WIDTH,
    parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BUS_WIDTH-1:0] unsync_bus,
    input  logic                 bus_enable,
    input  logic                 out_ready,
    input  logic                 overrun_clr,
    output logic [BUS_WIDTH-1:0] sync_bus,
    output logic                 out_valid,
    output logic                 enable_pulse,
    output logic                 overrun,
    output logic [CNT_WIDTH-1:0] drop_cnt
);

    generate
        if (NUM_STAGES < 2) begin : g_bad_stages
            $error("data_sync: NUM_STAGES must be >= 2");
        end
    endgenerate

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    sync_state_e state;
    logic        en_s;
    logic        en_s_d;
    logic        pulse_c;
    logic        drop_c;

    bit_sync #(
        .WIDTH      (1),
        .NUM_STAGES (NUM_STAGES)
    ) u_en_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus_enable),
        .q   (en_s)
    );

    assign pulse_c = en_s & ~en_s_d;
    // A drop is a new word arriving while the slot is full and not being drained.
    assign drop_c  = (state == ST_FULL) & ~out_ready & pulse_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            en_s_d       <= 1'b0;
            enable_pulse <= 1'b0;
        end else begin
            en_s_d       <= en_s;
            enable_pulse <= pulse_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            sync_bus  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pulse_c) begin
                        state     <= ST_FULL;
                        out_valid <= 1'b1;
                        sync_bus  <= unsync_bus;
                    end
                end
                ST_FULL: begin
                    if (out_ready) begin
                        if (pulse_c) begin
                            sync_bus <= unsync_bus;
                        end else begin
                            state     <= ST_IDLE;
                            out_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    // A drop on the same edge as a clear restarts the count at one.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun  <= 1'b0;
            drop_cnt <= '0;
        end else if (drop_c) begin
            overrun <= 1'b1;
            if (overrun_clr) begin
                drop_cnt <= CNT_ONE;
            end else if (!(&drop_cnt)) begin
                drop_cnt <= drop_cnt + CNT_ONE;
            end
        end else if (overrun_clr) begin
            overrun  <= 1'b0;
            drop_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_data_sync.sv
// Directed bench for data_sync with hand-computed expectations.
module tb_data_sync;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] unsync_bus;
    logic       bus_enable;
    logic       out_ready;
    logic       overrun_clr;
    logic [7:0] sync_bus;
    logic       out_valid;
    logic       enable_pulse;
    logic       overrun;
    logic [3:0] drop_cnt;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    data_sync dut (
        .clk          (clk),
        .rst          (rst),
        .unsync_bus   (unsync_bus),
        .bus_enable   (bus_enable),
        .out_ready    (out_ready),
        .overrun_clr  (overrun_clr),
        .sync_bus     (sync_bus),
        .out_valid    (out_valid),
        .enable_pulse (enable_pulse),
        .overrun      (overrun),
        .drop_cnt     (drop_cnt)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Raise bus_enable with a word; returns just after the capture edge (E+2).
    task automatic word_on(input logic [7:0] w);
        unsync_bus = w;
        bus_enable = 1'b1;
        cyc(3);
    endtask

    // Keep enable high a few more cycles, then low long enough to re-arm.
    task automatic word_off(input int n_hold);
        cyc(n_hold);
        bus_enable = 1'b0;
        cyc(4);
    endtask

    initial begin
        rst         = 1'b1;
        bus_enable  = 1'b1;
        unsync_bus  = 8'h5A;
        out_ready   = 1'b0;
        overrun_clr = 1'b0;

        // 1: reset with bus_enable high, capture on 3rd edge after release
        cyc(1);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_pulse", {31'd0, enable_pulse}, 32'd0);
        chk("rst_bus", {24'd0, sync_bus}, 32'd0);
        chk("rst_ovr", {31'd0, overrun}, 32'd0);
        chk("rst_cnt", {28'd0, drop_cnt}, 32'd0);
        cyc(1);
        chk("rst2_valid", {31'd0, out_valid}, 32'd0);
        rst = 1'b0;
        cyc(2);
        chk("rel_r2_valid", {31'd0, out_valid}, 32'd0);
        chk("rel_r2_pulse", {31'd0, enable_pulse}, 32'd0);
        cyc(1);
        chk("rel_r3_pulse", {31'd0, enable_pulse}, 32'd1);
        chk("rel_r3_valid", {31'd0, out_valid}, 32'd1);
        chk("rel_r3_bus", {24'd0, sync_bus}, 32'h5A);
        bus_enable = 1'b0;
        out_ready  = 1'b1;
        cyc(1);
        chk("rel_drain", {31'd0, out_valid}, 32'd0);
        cyc(4);

        // 2: single word, consumer ready
        out_ready = 1'b1;
        unsync_bus = 8'hA5;
        bus_enable = 1'b1;
        cyc(2);
        chk("t2_e1_pulse", {31'd0, enable_pulse}, 32'd0);
        cyc(1);
        chk("t2_pulse", {31'd0, enable_pulse}, 32'd1);
        chk("t2_bus", {24'd0, sync_bus}, 32'hA5);
        chk("t2_valid", {31'd0, out_valid}, 32'd1);
        cyc(1);
        chk("t2_valid_1cyc", {31'd0, out_valid}, 32'd0);
        chk("t2_pulse_1cyc", {31'd0, enable_pulse}, 32'd0);
        word_off(2);
        chk("t2_no_2nd_pulse", {31'd0, enable_pulse}, 32'd0);
        chk("t2_bus_hold", {24'd0, sync_bus}, 32'hA5);

        // 3: backpressure holds the word
        out_ready = 1'b0;
        word_on(8'h3C);
        chk("t3_valid", {31'd0, out_valid}, 32'd1);
        word_off(3);
        chk("t3_valid_held", {31'd0, out_valid}, 32'd1);
        chk("t3_bus_held", {24'd0, sync_bus}, 32'h3C);
        out_ready = 1'b1;
        cyc(1);
        chk("t3_drained", {31'd0, out_valid}, 32'd0);
        chk("t3_bus_after", {24'd0, sync_bus}, 32'h3C);
        out_ready = 1'b0;

        // 4: drop while full, then clear
        word_on(8'h11);
        word_off(3);
        word_on(8'h22);
        chk("t4_bus", {24'd0, sync_bus}, 32'h11);
        chk("t4_ovr", {31'd0, overrun}, 32'd1);
        chk("t4_cnt", {28'd0, drop_cnt}, 32'd1);
        chk("t4_pulse", {31'd0, enable_pulse}, 32'd1);
        word_off(3);
        overrun_clr = 1'b1;
        cyc(1);
        overrun_clr = 1'b0;
        chk("t4_clr_ovr", {31'd0, overrun}, 32'd0);
        chk("t4_clr_cnt", {28'd0, drop_cnt}, 32'd0);
        chk("t4_clr_valid", {31'd0, out_valid}, 32'd1);
        // drop coinciding with clear: set wins, count restarts at 1
        word_on(8'h55);
        word_off(3);
        overrun_clr = 1'b1;
        cyc(1);
        chk("t4_clr_cnt0", {28'd0, drop_cnt}, 32'd0);
        word_on(8'h66);
        word_on(8'h66);
        overrun_clr = 1'b0;
        out_ready = 1'b1;
        cyc(1);
        out_ready = 1'b0;
        bus_enable = 1'b0;
        cyc(4);
        unsync_bus = 8'h66;
        bus_enable = 1'b1;
        cyc(2);
        chk("t4b_pre_valid", {31'd0, out_valid}, 32'd0);
        cyc(1);
        chk("t4b_full", {31'd0, out_valid}, 32'd1);
        word_off(3);
        unsync_bus = 8'h67;
        bus_enable = 1'b1;
        cyc(2);
        overrun_clr = 1'b1;
        cyc(1);
        overrun_clr = 1'b0;
        chk("t4b_set_wins_ovr", {31'd0, overrun}, 32'd1);
        chk("t4b_set_wins_cnt", {28'd0, drop_cnt}, 32'd1);
        chk("t4b_bus", {24'd0, sync_bus}, 32'h66);
        word_off(3);
        overrun_clr = 1'b1;
        cyc(1);
        overrun_clr = 1'b0;
        out_ready = 1'b1;
        cyc(1);
        chk("t4b_drain", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b0;

        // 5: new word arrives on the same edge the consumer takes the old one
        word_on(8'h33);
        word_off(3);
        chk("t5_hold33", {24'd0, sync_bus}, 32'h33);
        unsync_bus = 8'h44;
        bus_enable = 1'b1;
        cyc(2);
        out_ready = 1'b1;
        cyc(1);
        out_ready = 1'b0;
        chk("t5_bus", {24'd0, sync_bus}, 32'h44);
        chk("t5_valid", {31'd0, out_valid}, 32'd1);
        chk("t5_ovr", {31'd0, overrun}, 32'd0);
        chk("t5_cnt", {28'd0, drop_cnt}, 32'd0);
        word_off(3);
        chk("t5_valid_held", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        cyc(1);
        out_ready = 1'b0;

        // 6: 20 words into a stalled slot, counter saturates
        word_on(8'h01);
        word_off(3);
        for (int i = 2; i <= 20; i++) begin
            word_on(i[7:0]);
            word_off(3);
            if (i == 3) chk("t6_cnt_mid", {28'd0, drop_cnt}, 32'd2);
        end
        chk("t6_cnt_sat", {28'd0, drop_cnt}, 32'hF);
        chk("t6_ovr", {31'd0, overrun}, 32'd1);
        chk("t6_bus_first", {24'd0, sync_bus}, 32'h01);
        chk("t6_valid", {31'd0, out_valid}, 32'd1);

        // 7: reset mid-operation discards the word, chain refills afterwards
        unsync_bus = 8'h77;
        bus_enable = 1'b1;
        cyc(1);
        rst = 1'b1;
        cyc(1);
        chk("t7_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("t7_rst_cnt", {28'd0, drop_cnt}, 32'd0);
        chk("t7_rst_bus", {24'd0, sync_bus}, 32'd0);
        rst = 1'b0;
        cyc(2);
        chk("t7_r2_valid", {31'd0, out_valid}, 32'd0);
        cyc(1);
        chk("t7_r3_valid", {31'd0, out_valid}, 32'd1);
        chk("t7_r3_pulse", {31'd0, enable_pulse}, 32'd1);
        chk("t7_r3_bus", {24'd0, sync_bus}, 32'h77);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
